// File: rtl/ad7606_seq.sv
// rtl/ad7606_seq.sv - AD7606 sequencer: reset/settle, periodic conv_start, busy/frame watchdog, frame handshake.
// Optional frame overrun counter built when AD_SEQ_OVERRUN_CNT_EN is defined.
module ad7606_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] wave_freq,
  input  logic [2:0] os_cfg,
  input  logic       ad_busy,
  input  logic       frame_done,
  input  logic       frame_ack,
  input  logic       err_clr,
  output logic       ad_reset,
  output logic [2:0] ad_os,
  output logic       conv_start,
  output logic       frame_valid,
  output logic       err_timeout,
  output logic [7:0] ovr_cnt
);
  localparam logic [2:0] ST_RST_PULSE    = 3'd0;
  localparam logic [2:0] ST_SETTLE       = 3'd1;
  localparam logic [2:0] ST_IDLE         = 3'd2;
  localparam logic [2:0] ST_WAIT_TICK    = 3'd3;
  localparam logic [2:0] ST_WAIT_BUSY_HI = 3'd4;
  localparam logic [2:0] ST_WAIT_BUSY_LO = 3'd5;
  localparam logic [2:0] ST_WAIT_FRAME   = 3'd6;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [9:0]  r_cnt;
  logic [11:0] r_tick_cnt;
  logic [11:0] w_tick_max;
  logic [1:0]  r_wf;
  logic [2:0]  r_ad_os;
  logic        r_os_loaded;
  logic        r_frame_valid;
  logic        r_err;
  logic        w_tick_run;
  logic        w_tick;
  logic        w_os_match;
  logic        w_timeout;

  always_comb begin
    case (r_wf)
      2'b00:   w_tick_max = 12'd3999;
      2'b01:   w_tick_max = 12'd1999;
      2'b10:   w_tick_max = 12'd799;
      default: w_tick_max = 12'd399;
    endcase
  end

  // Tick counter only runs while sampling; ticks outside WAIT_TICK are simply lost.
  assign w_tick_run = (r_state == ST_WAIT_TICK) || (r_state == ST_WAIT_BUSY_HI) ||
                      (r_state == ST_WAIT_BUSY_LO) || (r_state == ST_WAIT_FRAME);
  assign w_tick     = w_tick_run && (r_tick_cnt == w_tick_max);
  assign w_os_match = (os_cfg == r_ad_os);

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_RST_PULSE:    if (r_cnt == 10'd3) w_next = ST_SETTLE;
      ST_SETTLE:       if (r_cnt == 10'd99) w_next = ST_IDLE;
      ST_IDLE: begin
        if (!w_os_match)  w_next = ST_RST_PULSE;
        else if (enable)  w_next = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (!enable || !w_os_match) w_next = ST_IDLE;
        else if (w_tick)            w_next = ST_WAIT_BUSY_HI;
      end
      ST_WAIT_BUSY_HI: begin
        if (ad_busy)               w_next = ST_WAIT_BUSY_LO;
        else if (r_cnt == 10'd7)   w_timeout = 1'b1;
      end
      ST_WAIT_BUSY_LO: begin
        if (!ad_busy)              w_next = ST_WAIT_FRAME;
        else if (r_cnt == 10'd1023) w_timeout = 1'b1;
      end
      ST_WAIT_FRAME: begin
        if (frame_done)            w_next = ST_WAIT_TICK;
        else if (r_cnt == 10'd63)  w_timeout = 1'b1;
      end
      default:                     w_next = ST_RST_PULSE;
    endcase
    if (w_timeout) w_next = ST_RST_PULSE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RST_PULSE;
      r_cnt         <= '0;
      r_tick_cnt    <= '0;
      r_wf          <= '0;
      r_ad_os       <= '0;
      r_os_loaded   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 10'd0 : r_cnt + 10'd1;
      // Rate select is only picked up at a period boundary or while the counter is parked.
      if (!w_tick_run || w_tick) begin
        r_tick_cnt <= '0;
        r_wf       <= wave_freq;
      end else begin
        r_tick_cnt <= r_tick_cnt + 12'd1;
      end
      if (!r_os_loaded) begin
        r_ad_os     <= os_cfg;
        r_os_loaded <= 1'b1;
      end else if ((r_state == ST_IDLE) && !w_os_match) begin
        r_ad_os <= os_cfg;
      end
      if (frame_done)     r_frame_valid <= 1'b1;
      else if (frame_ack) r_frame_valid <= 1'b0;
      if (w_timeout)      r_err <= 1'b1;
      else if (err_clr)   r_err <= 1'b0;
    end
  end

`ifdef AD_SEQ_OVERRUN_CNT_EN
  logic [7:0] r_ovr_cnt;
  logic       w_overrun;

  assign w_overrun = frame_done && r_frame_valid && !frame_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_ovr_cnt <= '0;
    else if (err_clr)                        r_ovr_cnt <= '0;
    else if (w_overrun && r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
  end

  assign ovr_cnt = r_ovr_cnt;
`else
  assign ovr_cnt = 8'd0;
`endif

  assign ad_reset    = (r_state == ST_RST_PULSE);
  assign ad_os       = r_ad_os;
  assign conv_start  = (r_state == ST_WAIT_TICK) && enable && w_os_match && w_tick;
  assign frame_valid = r_frame_valid;
  assign err_timeout = r_err;

endmodule

// File: doc/ad7606_seq.md
AD7606_SEQ -- requirements
Module: ad7606_seq

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: ports clk and rst_n.
REQ-002 clk  in  1  4 MHz system clock; all logic on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 enable  in  1  1 = periodic sampling runs; 0 = stop after current frame.
REQ-005 wave_freq  in  2  sample rate select: 00=1 kHz, 01=2 kHz, 10=5 kHz, 11=10 kHz.
REQ-006 os_cfg  in  3  requested AD7606 oversampling ratio.
REQ-007 ad_busy  in  1  AD7606 BUSY pin.
REQ-008 frame_done  in  1  one-cycle pulse from capture FSM after CH8 read.
REQ-009 frame_ack  in  1  consumer acknowledges frame_valid.
REQ-010 err_clr  in  1  one-cycle pulse, clears err_timeout.
REQ-011 ad_reset  out  1  AD7606 RESET pin, active high.
REQ-012 ad_os  out  3  applied oversampling ratio.
REQ-013 conv_start  out  1  one-cycle pulse that starts one conversion/readout.
REQ-014 frame_valid  out  1  new 8-channel frame available.
REQ-015 err_timeout  out  1  sticky watchdog error flag.
REQ-016 ovr_cnt  out  8  frame overrun count (see Configuration).

Function
REQ-017 Period P SHALL be 4000/2000/800/400 clk for wave_freq 00/01/10/11; a 12-bit tick counter counts 0..P-1 and wraps, emitting tick at P-1.
REQ-018 wave_freq SHALL be sampled only at tick counter wrap; a mid-period change takes effect on the next period.
REQ-019 States SHALL be RST_PULSE, SETTLE, IDLE, WAIT_TICK, WAIT_BUSY_HI, WAIT_BUSY_LO, WAIT_FRAME.
REQ-020 RST_PULSE: ad_reset=1 for exactly 4 clk, then SETTLE.
REQ-021 SETTLE: wait 100 clk (25 us), then IDLE.
REQ-022 IDLE: if os_cfg != ad_os, load ad_os<=os_cfg and go to RST_PULSE; else if enable=1, clear tick counter and go to WAIT_TICK.
REQ-023 WAIT_TICK: on tick, assert conv_start for 1 clk and go to WAIT_BUSY_HI; if enable=0, go to IDLE.
REQ-024 WAIT_BUSY_HI: ad_busy=1 within 8 clk after conv_start, go to WAIT_BUSY_LO; else timeout.
REQ-025 WAIT_BUSY_LO: ad_busy=0 within 1024 clk, go to WAIT_FRAME; else timeout.
REQ-026 WAIT_FRAME: frame_done within 64 clk, go to WAIT_TICK; else timeout.
REQ-027 On any timeout SHALL set err_timeout=1 and go to RST_PULSE.
REQ-028 The tick counter SHALL free-run in all states except RST_PULSE/SETTLE/IDLE; a tick arriving before WAIT_TICK is re-entered SHALL be dropped, not queued.
REQ-029 frame_valid SHALL set the cycle after frame_done and clear the cycle after frame_ack; frame_ack with frame_done in the same cycle leaves frame_valid=1.
REQ-030 frame_done while frame_valid=1 and no frame_ack SHALL count as overrun.
REQ-031 err_clr SHALL clear err_timeout; a timeout in the same cycle wins (flag stays 1).
REQ-032 conv_start SHALL never assert outside WAIT_TICK and never on two consecutive cycles.

Reset
REQ-033 On rst_n=0: state=RST_PULSE, ad_reset=1, ad_os=os_cfg sampled at reset release (000 while reset asserted), conv_start=0, frame_valid=0, err_timeout=0, ovr_cnt=0, all counters 0.
REQ-034 Reset mid-conversion SHALL abort immediately; after release the full 4+100 clk reset/settle sequence SHALL run before any conv_start.

Configuration
REQ-035 Macro AD_SEQ_OVERRUN_CNT_EN: when defined, ovr_cnt is an 8-bit counter incrementing per overrun, saturating at 255, cleared by err_clr; when undefined, ovr_cnt is tied to 0 and no counter is built.

Verification
REQ-036 Reset release, os_cfg=3'b010, enable=1 -> ad_reset high 4 clk, first conv_start 104+P clk after release, ad_os=010.
REQ-037 wave_freq=11, BUSY model 20 clk, frame_done 30 clk after BUSY low -> conv_start every 400 clk, frame_valid pulses per frame with ack.
REQ-038 ad_busy held 0 after conv_start -> err_timeout=1 at 9th clk, ad_reset re-asserted 4 clk; err_clr -> flag 0.
REQ-039 os_cfg changed 010->100 while running -> after current frame, IDLE, RST_PULSE, then sampling resumes with ad_os=100.
REQ-040 frame_ack withheld for 3 frames with macro defined -> ovr_cnt=2; undefined -> ovr_cnt=0.
REQ-041 wave_freq 00->11 mid-period -> current 4000-clk period completes, next period 400 clk.
